bn_denorm: RTL and testbench

- Inverse of the batch-norm normaliser: rebuilds x = y*std + mean from normalised FP16 vectors and stored statistics (mean, std).
- Sits downstream of the normaliser and the statistics path, for example in residual or reconstruction datapaths.
- Statistics load through a valid/ready port. Vectors stream through a 2-stage valid/ready pipeline.
- A small FSM ensures statistics change only when the pipeline is empty.

---
 rtl/bn_denorm_pkg.sv | 101 ++++++++++
 rtl/bn_denorm_lane.sv | 44 ++++
 rtl/bn_denorm.sv | 150 +++++++++++++++
 tb/tb_bn_denorm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_denorm_pkg.sv
// Shared definitions for the batch-norm denormaliser: FP16 constants,
// FSM encoding and the combinational FP16 multiply/add helpers.
package bn_denorm_pkg;

    localparam int FP_W = 16;

    localparam logic [FP_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Subnormals flush to zero, results truncate, overflow saturates to inf.
    function automatic logic [15:0] floatMult(input logic [15:0] a,
                                              input logic [15:0] b);
        logic              s;
        logic [21:0]       p;
        logic signed [6:0] e;
        logic [9:0]        m;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
            return {s, 15'd0};
        end
        p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]}) - 7'sd15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 7'sd1;
        end else begin
            m = p[19:10];
        end
        if (e >= 7'sd31) begin
            return {s, 5'h1F, 10'd0};
        end
        if (e <= 7'sd0) begin
            return {s, 15'd0};
        end
        return {s, e[4:0], m};
    endfunction

    function automatic logic [15:0] floatAdd(input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0]       x;
        logic [15:0]       y;
        logic [4:0]        d;
        logic [13:0]       mx;
        logic [13:0]       my;
        logic [13:0]       n;
        logic [14:0]       s;
        logic signed [6:0] e;
        if (a[14:10] == 5'd0) begin
            return b;
        end
        if (b[14:10] == 5'd0) begin
            return a;
        end
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[14:10] - y[14:10];
        mx = {1'b1, x[9:0], 3'b000};
        my = (d > 5'd13) ? 14'd0 : ({1'b1, y[9:0], 3'b000} >> d);
        e  = $signed({2'b00, x[14:10]});
        if (x[15] == y[15]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[14]) begin
                n = s[14:1];
                e = e + 7'sd1;
            end else begin
                n = s[13:0];
            end
        end else begin
            n = mx - my;
            // exact cancellation yields +0
            if (n == 14'd0) begin
                return FP16_ZERO;
            end
            for (int i = 0; i < 13; i++) begin
                if (!n[13]) begin
                    n = n << 1;
                    e = e - 7'sd1;
                end
            end
        end
        if (e >= 7'sd31) begin
            return {x[15], 5'h1F, 10'd0};
        end
        if (e <= 7'sd0) begin
            return {x[15], 15'd0};
        end
        return {x[15], e[4:0], n[12:3]};
    endfunction

endpackage

// File: rtl/bn_denorm_lane.sv
// One FP16 lane of the denormaliser: stage 1 scales by std,
// stage 2 adds the mean. Enables come from the shared top-level control.
module bn_denorm_lane
    import bn_denorm_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ld1_i,
    input  logic            ld2_i,
    input  logic [FP_W-1:0] y_i,
    input  logic [FP_W-1:0] std_i,
    input  logic [FP_W-1:0] mean_i,
    output logic [FP_W-1:0] x_o
);

    logic [FP_W-1:0] m_q;
    logic [FP_W-1:0] m_d;
    logic [FP_W-1:0] x_q;
    logic [FP_W-1:0] x_d;

    always_comb begin
        m_d = m_q;
        x_d = x_q;
        if (ld1_i) begin
            m_d = floatMult(y_i, std_i);
        end
        if (ld2_i) begin
            x_d = floatAdd(m_q, mean_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_q <= FP16_ZERO;
            x_q <= FP16_ZERO;
        end else begin
            m_q <= m_d;
            x_q <= x_d;
        end
    end

    assign x_o = x_q;

endmodule

// File: rtl/bn_denorm.sv
// Batch-norm denormaliser x = y*std + mean: statistics port, two-stage
// valid/ready vector pipeline, and an FSM that swaps stats only when empty.
module bn_denorm
    import bn_denorm_pkg::*;
#(
    parameter int size       = 4,
    parameter int channel    = 1,
    parameter int DATA_WIDTH = FP_W
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    stat_valid,
    output logic                                    stat_ready,
    input  logic [DATA_WIDTH-1:0]                   stat_mean,
    input  logic [DATA_WIDTH-1:0]                   stat_std,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [0:DATA_WIDTH*(size/channel)-1]    in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [0:DATA_WIDTH*(size/channel)-1]    out_data,
    output logic                                    stats_loaded,
    output logic [15:0]                             vec_count
);

    localparam int N = size / channel;

    state_e          state_q;
    state_e          state_d;
    logic            v1_q;
    logic            v1_d;
    logic            v2_q;
    logic            v2_d;
    logic [FP_W-1:0] mean_q;
    logic [FP_W-1:0] mean_d;
    logic [FP_W-1:0] std_q;
    logic [FP_W-1:0] std_d;
    logic            loaded_q;
    logic            loaded_d;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_d;

    logic adv1;
    logic adv2;
    logic in_fire;
    logic out_fire;

    assign adv1     = !v2_q || out_ready;
    assign adv2     = adv1 && v1_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = v2_q && out_ready;

    always_comb begin
        state_d    = state_q;
        mean_d     = mean_q;
        std_d      = std_q;
        loaded_d   = loaded_q;
        stat_ready = 1'b0;
        in_ready   = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                stat_ready = 1'b1;
                if (stat_valid) begin
                    mean_d   = stat_mean;
                    std_d    = stat_std;
                    loaded_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // a pending stats update blocks new vectors
                in_ready = !stat_valid && (!v1_q || adv1);
                if (stat_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                stat_ready = !v1_q && !v2_q;
                if (!stat_valid) begin
                    state_d = S_RUN;
                end else if (stat_ready) begin
                    mean_d   = stat_mean;
                    std_d    = stat_std;
                    loaded_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        v1_d  = v1_q;
        v2_d  = v2_q;
        cnt_d = cnt_q;
        if (in_fire) begin
            v1_d = 1'b1;
        end else if (adv1) begin
            v1_d = 1'b0;
        end
        if (adv2) begin
            v2_d = 1'b1;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
        if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            mean_q   <= FP16_ZERO;
            std_q    <= FP16_ZERO;
            loaded_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            mean_q   <= mean_d;
            std_q    <= std_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        bn_denorm_lane u_lane (
            .clk_i  (clk),
            .rst_i  (reset),
            .ld1_i  (in_fire),
            .ld2_i  (adv2),
            .y_i    (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .std_i  (std_q),
            .mean_i (mean_q),
            .x_o    (out_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign out_valid    = v2_q;
    assign stats_loaded = loaded_q;
    assign vec_count    = cnt_q;

endmodule

// File: tb/tb_bn_denorm.sv
// Randomised scoreboard bench for bn_denorm; expected vectors come from
// a real-valued model of x = y*std + mean over exactly representable values.
module tb_bn_denorm;

    localparam int N = 4;
    localparam int W = 16 * N;

    logic           clk = 1'b0;
    logic           reset;
    logic           stat_valid;
    logic           stat_ready;
    logic [15:0]    stat_mean;
    logic [15:0]    stat_std;
    logic           in_valid;
    logic           in_ready;
    logic [0:W-1]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [0:W-1]   out_data;
    logic           stats_loaded;
    logic [15:0]    vec_count;

    always #5 clk = ~clk;

    bn_denorm #(.size(4), .channel(1), .DATA_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .stat_valid   (stat_valid),
        .stat_ready   (stat_ready),
        .stat_mean    (stat_mean),
        .stat_std     (stat_std),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stats_loaded (stats_loaded),
        .vec_count    (vec_count)
    );

    int           n_checks = 0;
    int           n_err    = 0;
    int           n_out    = 0;
    logic [0:W-1] sb[$];
    real          m_mean   = 0.0;
    real          m_std    = 0.0;
    int           rdy_mode = 0;
    int           stall_left = 0;
    logic         acc;
    logic         lit_en   = 1'b0;
    logic [0:W-1] lit_exp;
    logic         saw_block;
    int           last_wait;

    real yv[13] = '{0.0, 0.5, -0.5, 1.0, -1.0, 1.5, -1.5,
                    2.0, -2.0, 3.0, -3.0, 0.25, -0.75};
    real sv[5]  = '{0.5, 1.0, 2.0, 4.0, 1.5};
    real mv[7]  = '{0.0, 1.0, -1.0, 2.0, -2.0, 0.5, -3.0};

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic real fp2real(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(int'(h[9:0])) / 1024.0;
        while (e > 15) begin v = v * 2.0; e--; end
        while (e < 15) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real2fp(input real r);
        logic s;
        real  a;
        int   e;
        int   m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = $rtoi((a - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [0:W-1] model(input logic [0:W-1] d);
        logic [0:W-1] r;
        logic [15:0]  y;
        r = '0;
        for (int i = 0; i < N; i++) begin
            y = d[i*16 +: 16];
            r[i*16 +: 16] = real2fp(fp2real(y) * m_std + m_mean);
        end
        return r;
    endfunction

    function automatic logic [0:W-1] rand_vec();
        logic [0:W-1] r;
        for (int i = 0; i < N; i++) begin
            r[i*16 +: 16] = real2fp(yv[$urandom_range(0, 12)]);
        end
        return r;
    endfunction

    // observe the upcoming edge at the negedge, then advance to posedge+1
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready;
        if (in_valid && !in_ready && !stat_valid) saw_block = 1'b1;
        if (stat_valid) check("in_ready_during_stat", 64'(in_ready), 64'd0);
        if (acc) sb.push_back(lit_en ? lit_exp : model(in_data));
        if (stat_valid && stat_ready) begin
            check("stat_ready_pipe_empty", 64'(sb.size()), 64'd0);
            m_mean = fp2real(stat_mean);
            m_std  = fp2real(stat_std);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:W-1] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            tick();
            k++;
        end
        in_valid  = 1'b0;
        last_wait = k;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic load_stats(input logic [15:0] mn, input logic [15:0] sd,
                              input logic hold_in, output int waited);
        int  k;
        logic got;
        stat_valid = 1'b1;
        stat_mean  = mn;
        stat_std   = sd;
        in_valid   = hold_in;
        in_data    = rand_vec();
        k = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            got = stat_ready;
            tick();
            k++;
        end
        stat_valid = 1'b0;
        in_valid   = 1'b0;
        waited     = k;
        if (!got) check("stat_timeout", 64'd0, 64'd1);
        check("stats_loaded_set", 64'(stats_loaded), 64'd1);
    endtask

    task automatic drain(output int cycles);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        cycles = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) out_ready = 1'b0;
            else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    initial begin
        logic prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_out_valid", 64'(out_valid), 64'd0);
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_valid", 64'(out_valid), 64'd1);
                check("vec_count", 64'(vec_count), 64'(16'(n_out)));
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        check("out_data", out_data, sb[0]);
                        if (out_ready) void'(sb.pop_front());
                    end
                    if (out_ready) n_out++;
                end
                prev_stall = out_valid && !out_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int dc;
        reset      = 1'b1;
        stat_valid = 1'b0;
        stat_mean  = '0;
        stat_std   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        saw_block  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_stat_ready", 64'(stat_ready), 64'd1);
        check("rst_stats_loaded", 64'(stats_loaded), 64'd0);
        check("rst_vec_count", 64'(vec_count), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset = 1'b0;

        in_valid = 1'b1;
        in_data  = rand_vec();
        repeat (5) begin
            tick();
            check("empty_in_ready", 64'(in_ready), 64'd0);
            check("empty_out_valid", 64'(out_valid), 64'd0);
            check("empty_stat_ready", 64'(stat_ready), 64'd1);
            check("empty_stats_loaded", 64'(stats_loaded), 64'd0);
        end
        in_valid = 1'b0;

        load_stats(16'h3C00, 16'h4000, 1'b0, w);
        lit_en  = 1'b1;
        lit_exp = {16'h4200, 16'hBC00, 16'h3C00, 16'h4000};
        send({16'h3C00, 16'hBC00, 16'h0000, 16'h3800});
        lit_en = 1'b0;
        check("latency_t1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_t2", 64'(out_valid), 64'd1);
        drain(dc);
        check("count_after_one", 64'(vec_count), 64'd1);

        for (int k = 0; k < 8; k++) begin
            send(rand_vec());
            check("b2b_accept", 64'(last_wait), 64'd1);
        end
        drain(dc);
        check("b2b_no_bubble", 64'(dc), 64'd2);
        check("count_after_b2b", 64'(vec_count), 64'd9);

        saw_block = 1'b0;
        send(rand_vec());
        send(rand_vec());
        stall_left = 5;
        for (int k = 0; k < 6; k++) send(rand_vec());
        check("stall_in_ready_drop", 64'(saw_block), 64'd1);
        drain(dc);
        check("count_after_stall", 64'(vec_count), 64'd17);

        send(rand_vec());
        send(rand_vec());
        load_stats(16'h0000, 16'h4400, 1'b1, w);
        check("drain_took_cycles", 64'(w >= 2), 64'd1);
        lit_en  = 1'b1;
        lit_exp = {4{16'h4400}};
        send({4{16'h3C00}});
        lit_en = 1'b0;
        drain(dc);
        check("count_after_drain", 64'(vec_count), 64'd20);

        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 14) == 0) begin
                load_stats(real2fp(mv[$urandom_range(0, 6)]),
                           real2fp(sv[$urandom_range(0, 4)]),
                           1'($urandom_range(0, 1)), w);
            end
            repeat ($urandom_range(0, 2)) tick();
            send(rand_vec());
        end
        drain(dc);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(rand_vec());
        send(rand_vec());
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_stats_loaded", 64'(stats_loaded), 64'd0);
        sb.delete();
        n_out = 0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd0);
        check("post_rst_stat_ready", 64'(stat_ready), 64'd1);
        check("post_rst_vec_count", 64'(vec_count), 64'd0);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        load_stats(real2fp(-2.0), real2fp(1.5), 1'b0, w);
        for (int k = 0; k < 4; k++) send(rand_vec());
        drain(dc);
        check("count_after_reset", 64'(vec_count), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
